// File: rtl/tetris_pkg.sv
// Shared keycode constants and key-repeat FSM states for the tetris input path.
package tetris_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_W    = 8'h1A;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  // Map a raw keycode to itself if it is a move key, otherwise to KEY_NONE.
  function automatic logic [7:0] move_key(input logic [7:0] code);
    logic [7:0] k;
    case (code)
      KEY_A, KEY_D, KEY_S, KEY_W: k = code;
      default:                    k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detector producing a single-cycle pulse.
module sync_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q_rise
);

  logic       meta;
  logic       sync;
  logic       sync_d;
  logic [2:0] warm;

  // Synchronise, delay one more stage, and flag 0->1 transitions. The warm
  // shift register masks the detector until sync_d holds a real sample, so a
  // level that is already high when reset lifts is not mistaken for an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      warm   <= '0;
      q_rise <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
      warm   <= {warm[1:0], 1'b1};
      q_rise <= warm[2] & sync & ~sync_d;
    end
  end

endmodule

// File: rtl/key_repeater.sv
// Keyboard auto-repeat: posts a move event on press, after DAS_FRAMES frames of
// holding, then every ARR_FRAMES frames; the newest event is held pending until
// the game logic acknowledges it.
module key_repeater
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_FRAMES = 10,
  parameter int unsigned ARR_FRAMES = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode_in,
  input  logic       frame_clk,
  input  logic       key_ack,
  output logic [7:0] keycode_out,
  output logic       key_valid
);

  localparam logic [5:0] DAS_LOAD = 6'(DAS_FRAMES);
  localparam logic [5:0] ARR_LOAD = 6'(ARR_FRAMES);

  rep_state_t state, state_n;
  logic [5:0] cnt, cnt_n;
  logic [7:0] held_key, held_n;
  logic [7:0] key_norm;
  logic [7:0] ev_key;
  logic       post_ev;
  logic       frame_tick;

  assign key_norm = move_key(keycode_in);

  sync_edge u_frame_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (frame_clk),
    .q_rise  (frame_tick)
  );

  // FSM state, frame countdown and the key currently being held.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      held_key <= KEY_NONE;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      held_key <= held_n;
    end
  end

  // Next-state logic: press/switch events, frame countdown, release to IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    held_n  = held_key;
    post_ev = 1'b0;
    ev_key  = held_key;
    case (state)
      IDLE: begin
        if (key_norm != KEY_NONE) begin
          post_ev = 1'b1;
          ev_key  = key_norm;
          held_n  = key_norm;
          cnt_n   = DAS_LOAD;
          state_n = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (key_norm == KEY_NONE) begin
          state_n = IDLE;
        end else if (key_norm != held_key) begin
          post_ev = 1'b1;
          ev_key  = key_norm;
          held_n  = key_norm;
          cnt_n   = DAS_LOAD;
          state_n = DELAY;
        end else if (frame_tick) begin
          // Reload instead of reaching zero, so cnt stays >= 1 while held.
          if (cnt <= 6'd1) begin
            post_ev = 1'b1;
            ev_key  = held_key;
            cnt_n   = ARR_LOAD;
            state_n = REPEAT;
          end else begin
            cnt_n = cnt - 6'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pending-move register: a new event overwrites and beats an acknowledge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_valid   <= 1'b0;
      keycode_out <= KEY_NONE;
    end else if (post_ev) begin
      key_valid   <= 1'b1;
      keycode_out <= ev_key;
    end else if (key_ack && key_valid) begin
      key_valid   <= 1'b0;
      keycode_out <= KEY_NONE;
    end
  end

endmodule

// File: tb/tb_key_repeater.sv
// Self-checking bench for key_repeater: directed scenarios plus random key /
// frame / ack traffic, compared each cycle against a frame-age reference model.
module tb_key_repeater;

  localparam int DAS = 10;
  localparam int ARR = 3;
  localparam int FP  = 8;   // Clk cycles per frame (half high, half low)

  logic       Clk        = 1'b0;
  logic       Reset_n    = 1'b0;
  logic [7:0] keycode_in = 8'h00;
  logic       frame_clk  = 1'b0;
  logic       key_ack    = 1'b0;
  logic [7:0] keycode_out;
  logic       key_valid;

  key_repeater #(
    .DAS_FRAMES (DAS),
    .ARR_FRAMES (ARR)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .keycode_in  (keycode_in),
    .frame_clk   (frame_clk),
    .key_ack     (key_ack),
    .keycode_out (keycode_out),
    .key_valid   (key_valid)
  );

  always #5 Clk = ~Clk;

  int   errors = 0;
  int   checks = 0;
  int   dut_ev = 0;
  logic prev_v = 1'b0;

  // Reference model: held key, frames held since press, pending event.
  logic       m_valid;
  logic [7:0] m_key;
  logic [7:0] m_held;
  int         m_age;
  logic [2:0] m_rise;   // frame rises in flight through the synchroniser
  logic       m_prevf;

  function automatic logic [7:0] recog(input logic [7:0] k);
    return (k == 8'h04 || k == 8'h07 || k == 8'h16 || k == 8'h1A) ? k : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_key   = 8'h00;
    m_held  = 8'h00;
    m_age   = 0;
    m_rise  = 3'b000;
    m_prevf = frame_clk;
  endtask

  // One Clk edge of the model. A frame rise driven before edge N is acted on
  // by the repeat logic at edge N+3.
  task automatic model_edge(input logic [7:0] k, input logic f, input logic a);
    logic       tick;
    logic       ev;
    logic [7:0] kn;
    logic [7:0] ek;
    tick    = m_rise[2];
    m_rise  = {m_rise[1:0], f & ~m_prevf};
    m_prevf = f;
    kn = recog(k);
    ev = 1'b0;
    ek = m_held;
    if (m_held == 8'h00) begin
      if (kn != 8'h00) begin ev = 1'b1; ek = kn; m_held = kn; m_age = 0; end
    end else if (kn == 8'h00) begin
      m_held = 8'h00;
    end else if (kn != m_held) begin
      ev = 1'b1; ek = kn; m_held = kn; m_age = 0;
    end else if (tick) begin
      m_age++;
      if (m_age >= DAS && ((m_age - DAS) % ARR) == 0) begin ev = 1'b1; ek = m_held; end
    end
    if (ev) begin
      m_valid = 1'b1;
      m_key   = ek;
    end else if (a && m_valid) begin
      m_valid = 1'b0;
      m_key   = 8'h00;
    end
  endtask

  // Drive inputs at the falling edge, clock once, check at the next falling edge.
  task automatic step(input logic [7:0] k, input logic f, input logic a);
    keycode_in = k;
    frame_clk  = f;
    key_ack    = a;
    model_edge(k, f, a);
    @(posedge Clk);
    @(negedge Clk);
    if (key_valid && !prev_v) dut_ev++;
    prev_v = key_valid;
    chk("valid", {7'b0, key_valid}, {7'b0, m_valid});
    chk("code", keycode_out, m_key);
  endtask

  // ack mode: 0 never, 1 whenever a move is pending, 2 always, 3 random.
  task automatic frames(input int n, input logic [7:0] k, input int mode);
    logic a;
    for (int i = 0; i < n * FP; i++) begin
      case (mode)
        1:       a = m_valid;
        2:       a = 1'b1;
        3:       a = ($urandom_range(0, 3) == 0);
        default: a = 1'b0;
      endcase
      step(k, (i % FP) < FP / 2, a);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] keys [8];
    logic [7:0] rk;
    int         ph;
    int         len;
    keys = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h00, 8'h04};

    // Power-on reset.
    model_reset();
    repeat (3) @(negedge Clk);
    chk("reset_valid", {7'b0, key_valid}, 8'h00);
    chk("reset_code", keycode_out, 8'h00);
    Reset_n = 1'b1;
    idle(3);

    // Single press, pending one cycle later, cleared by ack.
    step(8'h04, 1'b0, 1'b0);
    chk("press_valid", {7'b0, key_valid}, 8'h01);
    chk("press_code", keycode_out, 8'h04);
    repeat (3) step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b1);
    chk("ack_valid", {7'b0, key_valid}, 8'h00);
    chk("ack_code", keycode_out, 8'h00);
    idle(4);

    // Hold D for 20 frames with immediate ack: press, 10, 13, 16, 19.
    dut_ev = 0;
    frames(20, 8'h07, 1);
    chk("hold20_events", 8'(dut_ev), 8'd5);
    idle(4);

    // Switch S -> A after 5 frames: immediate event, next after 10 frames.
    frames(5, 8'h16, 1);
    dut_ev = 0;
    frames(9, 8'h04, 1);
    chk("switch_events_9f", 8'(dut_ev), 8'd1);
    frames(1, 8'h04, 1);
    chk("switch_events_10f", 8'(dut_ev), 8'd2);
    idle(4);

    // Short tap stays pending; unrecognised key posts nothing.
    step(8'h1A, 1'b0, 1'b0);
    step(8'h1A, 1'b0, 1'b0);
    frames(3, 8'h00, 0);
    chk("tap_valid", {7'b0, key_valid}, 8'h01);
    chk("tap_code", keycode_out, 8'h1A);
    frames(1, 8'h2C, 0);
    chk("other_key_code", keycode_out, 8'h1A);
    step(8'h00, 1'b0, 1'b1);
    frames(1, 8'h2C, 0);
    chk("other_key_valid", {7'b0, key_valid}, 8'h00);
    idle(4);

    // Ack held high: coincident events still win.
    dut_ev = 0;
    frames(14, 8'h1A, 2);
    chk("ack_collide_events", 8'(dut_ev), 8'd3);
    idle(4);

    // Reset released with frame_clk already high: no spurious frame tick.
    frame_clk = 1'b1;
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_hi_valid", {7'b0, key_valid}, 8'h00);
    @(negedge Clk);
    Reset_n = 1'b1;
    prev_v  = 1'b0;
    dut_ev  = 0;
    for (int i = 0; i < FP / 2; i++) step(8'h04, 1'b1, m_valid);
    for (int i = 0; i < FP / 2; i++) step(8'h04, 1'b0, m_valid);
    frames(10, 8'h04, 1);
    chk("rst_hi_events", 8'(dut_ev), 8'd2);
    idle(4);

    // Reset in REPEAT with a move pending; still-held key is a fresh press.
    frames(12, 8'h04, 0);
    chk("pre_rst_valid", {7'b0, key_valid}, 8'h01);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, key_valid}, 8'h00);
    chk("mid_rst_code", keycode_out, 8'h00);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    prev_v  = 1'b0;
    step(8'h04, 1'b0, 1'b0);
    chk("post_rst_valid", {7'b0, key_valid}, 8'h01);
    chk("post_rst_code", keycode_out, 8'h04);
    idle(4);

    // Random traffic with a free-running frame strobe.
    ph = 0;
    for (int seg = 0; seg < 60; seg++) begin
      rk  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : keys[$urandom_range(0, 7)];
      len = $urandom_range(1, 24);
      for (int j = 0; j < len; j++) begin
        step(rk, (ph % FP) < FP / 2, $urandom_range(0, 3) == 0);
        ph++;
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
